// File: rtl/nor_cmd_sequencer.sv
// NOR flash command-frame sequencer: turns one command descriptor into chip-select framed byte
// transfers for the SPI shifter, with optional WREN prefix and RDSR busy polling.
module nor_cmd_sequencer #(
  parameter int unsigned ADDR_BYTES = 3,
  parameter int unsigned POLL_LIMIT = 65535,
  parameter int unsigned CS_GAP     = 2
) (
  input  logic        p_clk,
  input  logic        p_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic        cmd_has_addr,
  input  logic [8:0]  cmd_len,
  input  logic        cmd_write,
  input  logic        cmd_wren,
  input  logic [7:0]  wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  sh_tx,
  output logic        sh_start,
  input  logic        sh_done,
  input  logic [7:0]  sh_rx,
  output logic        s_css
);

  localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);
  localparam int unsigned GapW  = $clog2(CS_GAP + 1);

  typedef enum logic [3:0] {
    StIdle, StWrenOp, StGap1, StOp, StAddr, StData, StGap2, StPollOp, StPollRd, StGap3, StFin
  } state_e;

  state_e            state_q, state_d;
  logic              s_css_q, s_css_d;
  logic              sh_start_q, sh_start_d;
  logic [7:0]        sh_tx_q, sh_tx_d;
  logic              wdata_ready_q, wdata_ready_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              err_q, err_d;
  logic              wait_q, wait_d;
  logic              init_q;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]        addr_cnt_q, addr_cnt_d;
  logic [8:0]        len_cnt_q, len_cnt_d;
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [PollW-1:0]  poll_nxt;
  logic [23:0]       addr_sh_q, addr_sh_d;
  logic [7:0]        op_q, op_d;
  logic              has_addr_q, has_addr_d;
  logic              write_q, write_d;
  logic              wren_q, wren_d;
  logic              frame_end;
  logic              gap_last;

  assign poll_nxt = poll_cnt_q + PollW'(1);
  assign gap_last = (gap_cnt_q == GapW'(CS_GAP - 1));

  always_comb begin
    state_d       = state_q;
    s_css_d       = s_css_q;
    sh_start_d    = 1'b0;
    sh_tx_d       = sh_tx_q;
    wdata_ready_d = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = err_q;
    wait_d        = wait_q;
    gap_cnt_d     = gap_cnt_q;
    addr_cnt_d    = addr_cnt_q;
    len_cnt_d     = len_cnt_q;
    poll_cnt_d    = poll_cnt_q;
    addr_sh_d     = addr_sh_q;
    op_d          = op_q;
    has_addr_d    = has_addr_q;
    write_d       = write_q;
    wren_d        = wren_q;
    frame_end     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          op_d       = cmd_op;
          has_addr_d = cmd_has_addr;
          write_d    = cmd_write;
          wren_d     = cmd_wren;
          len_cnt_d  = cmd_len;
          // Left-align the used address bytes so the MSB byte always sits in [23:16].
          addr_sh_d  = cmd_addr << (8 * (3 - ADDR_BYTES));
          addr_cnt_d = '0;
          poll_cnt_d = '0;
          gap_cnt_d  = '0;
          err_d      = 1'b0;
          wait_d     = 1'b0;
          s_css_d    = 1'b0;
          state_d    = cmd_wren ? StWrenOp : StOp;
        end
      end
      StWrenOp: begin
        if (!wait_q) begin
          sh_start_d = 1'b1;
          sh_tx_d    = 8'h06;
          wait_d     = 1'b1;
        end else if (sh_done) begin
          wait_d    = 1'b0;
          s_css_d   = 1'b1;
          gap_cnt_d = '0;
          state_d   = StGap1;
        end
      end
      StGap1, StGap2, StGap3: begin
        if (gap_last) begin
          s_css_d = 1'b0;
          state_d = (state_q == StGap1) ? StOp : StPollOp;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      StOp: begin
        if (!wait_q) begin
          sh_start_d = 1'b1;
          sh_tx_d    = op_q;
          wait_d     = 1'b1;
        end else if (sh_done) begin
          wait_d = 1'b0;
          if (has_addr_q)          state_d   = StAddr;
          else if (len_cnt_q != 0) state_d   = StData;
          else                     frame_end = 1'b1;
        end
      end
      StAddr: begin
        if (!wait_q) begin
          sh_start_d = 1'b1;
          sh_tx_d    = addr_sh_q[23:16];
          wait_d     = 1'b1;
        end else if (sh_done) begin
          wait_d     = 1'b0;
          addr_sh_d  = addr_sh_q << 8;
          addr_cnt_d = addr_cnt_q + 8'd1;
          if (addr_cnt_q == 8'(ADDR_BYTES - 1)) begin
            if (len_cnt_q != 0) state_d   = StData;
            else                frame_end = 1'b1;
          end
        end
      end
      StData: begin
        if (!wait_q) begin
          if (!write_q) begin
            sh_start_d = 1'b1;
            sh_tx_d    = 8'h00;
            wait_d     = 1'b1;
          end else if (wdata_valid) begin
            sh_start_d    = 1'b1;
            sh_tx_d       = wdata;
            wdata_ready_d = 1'b1;
            wait_d        = 1'b1;
          end
        end else if (sh_done) begin
          wait_d    = 1'b0;
          len_cnt_d = len_cnt_q - 9'd1;
          if (!write_q) begin
            rdata_d       = sh_rx;
            rdata_valid_d = 1'b1;
          end
          if (len_cnt_q == 9'd1) frame_end = 1'b1;
        end
      end
      StPollOp: begin
        if (!wait_q) begin
          sh_start_d = 1'b1;
          sh_tx_d    = 8'h05;
          wait_d     = 1'b1;
        end else if (sh_done) begin
          wait_d  = 1'b0;
          state_d = StPollRd;
        end
      end
      StPollRd: begin
        if (!wait_q) begin
          sh_start_d = 1'b1;
          sh_tx_d    = 8'h00;
          wait_d     = 1'b1;
        end else if (sh_done) begin
          wait_d     = 1'b0;
          s_css_d    = 1'b1;
          gap_cnt_d  = '0;
          poll_cnt_d = poll_nxt;
          if (!sh_rx[0]) begin
            err_d   = 1'b0;
            state_d = StFin;
          end else if (poll_nxt == PollW'(POLL_LIMIT)) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            state_d = StGap3;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (frame_end) begin
      s_css_d   = 1'b1;
      gap_cnt_d = '0;
      state_d   = wren_q ? StGap2 : StFin;
    end
  end

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state_q       <= StIdle;
      s_css_q       <= 1'b1;
      sh_start_q    <= 1'b0;
      sh_tx_q       <= 8'h00;
      wdata_ready_q <= 1'b0;
      rdata_q       <= 8'h00;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
      wait_q        <= 1'b0;
      init_q        <= 1'b0;
      gap_cnt_q     <= '0;
      addr_cnt_q    <= '0;
      len_cnt_q     <= '0;
      poll_cnt_q    <= '0;
      addr_sh_q     <= '0;
      op_q          <= 8'h00;
      has_addr_q    <= 1'b0;
      write_q       <= 1'b0;
      wren_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_css_q       <= s_css_d;
      sh_start_q    <= sh_start_d;
      sh_tx_q       <= sh_tx_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
      wait_q        <= wait_d;
      init_q        <= 1'b1;
      gap_cnt_q     <= gap_cnt_d;
      addr_cnt_q    <= addr_cnt_d;
      len_cnt_q     <= len_cnt_d;
      poll_cnt_q    <= poll_cnt_d;
      addr_sh_q     <= addr_sh_d;
      op_q          <= op_d;
      has_addr_q    <= has_addr_d;
      write_q       <= write_d;
      wren_q        <= wren_d;
    end
  end

  // cmd_ready stays low until the first clock after reset release.
  assign cmd_ready   = init_q && (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StFin);
  assign err         = err_q;
  assign s_css       = s_css_q;
  assign sh_start    = sh_start_q;
  assign sh_tx       = sh_tx_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_nor_cmd_sequencer.sv
// Bench for nor_cmd_sequencer: randomized commands against a frame-level reference model, with a
// behavioural shifter and write-data producer.
module tb_nor_cmd_sequencer;

  localparam int unsigned CsGap     = 2;
  localparam int unsigned PollLimit = 3;

  logic        p_clk, p_reset_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic        cmd_has_addr;
  logic [8:0]  cmd_len;
  logic        cmd_write, cmd_wren;
  logic [7:0]  wdata;
  logic        wdata_valid, wdata_ready;
  logic [7:0]  rdata;
  logic        rdata_valid, busy, done, err;
  logic [7:0]  sh_tx;
  logic        sh_start, sh_done;
  logic [7:0]  sh_rx;
  logic        s_css;

  nor_cmd_sequencer #(
    .ADDR_BYTES (3),
    .POLL_LIMIT (PollLimit),
    .CS_GAP     (CsGap)
  ) u_dut (
    .p_clk        (p_clk),
    .p_reset_n    (p_reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_has_addr (cmd_has_addr),
    .cmd_len      (cmd_len),
    .cmd_write    (cmd_write),
    .cmd_wren     (cmd_wren),
    .wdata        (wdata),
    .wdata_valid  (wdata_valid),
    .wdata_ready  (wdata_ready),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .sh_tx        (sh_tx),
    .sh_start     (sh_start),
    .sh_done      (sh_done),
    .sh_rx        (sh_rx),
    .s_css        (s_css)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] act_tx[$], act_rd[$], resp_q[$], wq[$], stat_q[$];
  int         act_fl[$];
  int         done_cnt, hi_run, stall_left, stall_obs;
  int unsigned lat;
  logic       pend, prev_css, spur, stall_arm;
  logic [7:0] pend_rx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(0, 255));
  endfunction

  // Monitor, shifter model and write-data producer, all on the falling edge.
  always @(negedge p_clk) begin
    if (!p_reset_n) begin
      pend       = 1'b0;
      sh_done    = 1'b0;
      stall_left = 0;
      stall_obs  = 0;
      prev_css   = 1'b1;
      hi_run     = 0;
    end else begin
      if (stall_obs > 0) begin
        check_eq("stall_no_start", 32'(sh_start), 32'd0);
        check_eq("stall_css_low", 32'(s_css), 32'd0);
        stall_obs--;
      end
      if (!s_css && prev_css) begin
        check_eq("cs_gap_min", 32'(hi_run >= int'(CsGap)), 32'd1);
        act_fl.push_back(0);
      end
      hi_run   = s_css ? hi_run + 1 : 0;
      prev_css = s_css;
      if (done) done_cnt++;
      if (rdata_valid) act_rd.push_back(rdata);
      if (sh_start) begin
        check_eq("start_in_frame", 32'(s_css), 32'd0);
        check_eq("start_while_pending", 32'(pend), 32'd0);
      end
      sh_done = 1'b0;
      if (spur) begin
        sh_done = 1'b1;
        sh_rx   = rnd8();
        spur    = 1'b0;
      end else if (pend) begin
        if (lat == 0) begin
          sh_done = 1'b1;
          sh_rx   = pend_rx;
          pend    = 1'b0;
        end else begin
          lat--;
        end
      end
      if (sh_start) begin
        act_tx.push_back(sh_tx);
        if (act_fl.size() > 0) act_fl[act_fl.size()-1] = act_fl[act_fl.size()-1] + 1;
        pend    = 1'b1;
        lat     = $urandom_range(0, 2);
        pend_rx = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
      end
      if (wdata_ready) begin
        check_eq("wready_needs_valid", 32'(wdata_valid), 32'd1);
        if (wq.size() > 0) void'(wq.pop_front());
      end
      if (stall_arm && wq.size() == 4) begin
        stall_arm  = 1'b0;
        stall_left = 5;
        stall_obs  = 5;
      end
      if (stall_left > 0) begin
        wdata_valid = 1'b0;
        stall_left--;
      end else begin
        wdata_valid = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
      end
      wdata = (wq.size() > 0) ? wq[0] : 8'h00;
    end
  end

  task automatic run_cmd(input logic [7:0] op, input logic [23:0] addr, input logic ha,
                         input int len, input logic wr, input logic wren, input logic hold,
                         input logic fixed);
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    int         exp_fl[$];
    logic       exp_err;
    logic [7:0] b, st;
    logic       seen;
    act_tx.delete(); act_fl.delete(); act_rd.delete(); resp_q.delete(); wq.delete();
    done_cnt = 0;
    // Reference frames built straight from the command semantics.
    if (wren) begin
      exp_tx.push_back(8'h06); resp_q.push_back(rnd8()); exp_fl.push_back(1);
    end
    exp_tx.push_back(op); resp_q.push_back(rnd8());
    if (ha) for (int i = 2; i >= 0; i--) begin
      exp_tx.push_back(addr[8*i +: 8]); resp_q.push_back(rnd8());
    end
    for (int i = 0; i < len; i++) begin
      if (wr) begin
        b = fixed ? ((i % 2 == 0) ? 8'h5A : 8'hA5) : rnd8();
        wq.push_back(b); exp_tx.push_back(b); resp_q.push_back(rnd8());
      end else begin
        b = fixed ? 8'(8'hA0 + i) : rnd8();
        exp_tx.push_back(8'h00); resp_q.push_back(b); exp_rd.push_back(b);
      end
    end
    exp_fl.push_back(1 + (ha ? 3 : 0) + len);
    exp_err = 1'b0;
    if (wren) for (int p = 1; p <= int'(PollLimit); p++) begin
      st = (p - 1 < stat_q.size()) ? stat_q[p-1] : 8'h01;
      exp_tx.push_back(8'h05); exp_tx.push_back(8'h00);
      resp_q.push_back(rnd8()); resp_q.push_back(st);
      exp_fl.push_back(2);
      if (!st[0]) break;
      if (p == int'(PollLimit)) exp_err = 1'b1;
    end

    @(negedge p_clk);
    cmd_op = op; cmd_addr = addr; cmd_has_addr = ha; cmd_len = 9'(len);
    cmd_write = wr; cmd_wren = wren; cmd_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin seen = 1'b1; break; end
      @(negedge p_clk);
    end
    check_eq("ready_in_idle", 32'(seen), 32'd1);
    if (!seen) begin cmd_valid = 1'b0; return; end
    @(posedge p_clk); #1;
    if (!hold) cmd_valid = 1'b0;
    @(negedge p_clk);
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    check_eq("css_after_accept", 32'(s_css), 32'd0);
    check_eq("no_start_first_cycle", 32'(sh_start), 32'd0);
    if (hold) begin
      check_eq("ready_low_while_busy", 32'(cmd_ready), 32'd0);
      @(posedge p_clk); #1 cmd_valid = 1'b0;
    end
    @(negedge p_clk);
    check_eq("first_start", 32'(sh_start), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge p_clk);
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check_eq("err_at_done", 32'(err), 32'(exp_err));
      check_eq("css_high_at_done", 32'(s_css), 32'd1);
      @(negedge p_clk);
      check_eq("busy_after_done", 32'(busy), 32'd0);
      check_eq("done_one_cycle", 32'(done), 32'd0);
    end
    repeat (2) @(negedge p_clk);
    check_eq("done_count", 32'(done_cnt), 32'(seen ? 1 : 0));
    check_eq("frame_count", 32'(act_fl.size()), 32'(exp_fl.size()));
    for (int i = 0; i < exp_fl.size() && i < act_fl.size(); i++)
      check_eq("frame_len", 32'(act_fl[i]), 32'(exp_fl[i]));
    check_eq("tx_count", 32'(act_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < act_tx.size(); i++)
      check_eq("tx_byte", 32'(act_tx[i]), 32'(exp_tx[i]));
    check_eq("rd_count", 32'(act_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++)
      check_eq("rd_byte", 32'(act_rd[i]), 32'(exp_rd[i]));
  endtask

  task automatic reset_mid_addr();
    logic seen;
    act_tx.delete(); act_fl.delete(); act_rd.delete(); resp_q.delete(); wq.delete();
    done_cnt = 0;
    for (int i = 0; i < 16; i++) resp_q.push_back(rnd8());
    @(negedge p_clk);
    cmd_op = 8'h0B; cmd_addr = 24'hABCDEF; cmd_has_addr = 1'b1; cmd_len = 9'd4;
    cmd_write = 1'b0; cmd_wren = 1'b0; cmd_valid = 1'b1;
    @(posedge p_clk); #1 cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (act_tx.size() >= 2) begin seen = 1'b1; break; end
      @(negedge p_clk);
    end
    check_eq("reached_addr_phase", 32'(seen), 32'd1);
    #2 p_reset_n = 1'b0;
    #1;
    check_eq("rst_css_async", 32'(s_css), 32'd1);
    check_eq("rst_busy_async", 32'(busy), 32'd0);
    check_eq("rst_ready_low", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge p_clk);
    check_eq("no_done_on_reset", 32'(done_cnt), 32'd0);
    p_reset_n = 1'b1;
    @(negedge p_clk);
    check_eq("ready_after_rerelease", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    logic [23:0] a;
    logic        ha, wr, wren, hold;
    int          len;
    cmd_valid = 1'b0; cmd_op = 8'h00; cmd_addr = '0; cmd_has_addr = 1'b0; cmd_len = '0;
    cmd_write = 1'b0; cmd_wren = 1'b0; wdata = 8'h00; wdata_valid = 1'b0;
    sh_done = 1'b0; sh_rx = 8'h00; spur = 1'b0; stall_arm = 1'b0;
    pend = 1'b0; prev_css = 1'b1; hi_run = 0; done_cnt = 0; stall_left = 0; stall_obs = 0;
    p_reset_n = 1'b1;
    #2 p_reset_n = 1'b0;
    #1;
    check_eq("rst_s_css", 32'(s_css), 32'd1);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_sh_start", 32'(sh_start), 32'd0);
    check_eq("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    check_eq("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check_eq("rst_sh_tx", 32'(sh_tx), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    repeat (2) @(negedge p_clk);
    check_eq("ready_held_in_reset", 32'(cmd_ready), 32'd0);
    p_reset_n = 1'b1;
    @(negedge p_clk);
    check_eq("ready_after_release", 32'(cmd_ready), 32'd1);

    // Stray sh_done while idle must do nothing.
    act_tx.delete();
    spur = 1'b1;
    repeat (4) @(negedge p_clk);
    check_eq("spur_no_start", 32'(act_tx.size()), 32'd0);
    check_eq("spur_css_high", 32'(s_css), 32'd1);
    check_eq("spur_not_busy", 32'(busy), 32'd0);

    stat_q.delete();
    run_cmd(8'h03, 24'h012345, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    stat_q = '{8'h03, 8'h03, 8'h00};
    run_cmd(8'h02, 24'h000100, 1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b1);
    stat_q = '{8'h00};
    stall_arm = 1'b1;
    run_cmd(8'h02, 24'h3C0F00, 1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("stall_triggered", 32'(stall_arm), 32'd0);
    stat_q = '{8'h01, 8'h01, 8'h01, 8'h01};
    run_cmd(8'h20, 24'h001000, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    stat_q.delete();
    run_cmd(8'h06, 24'h000000, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset_mid_addr();
    run_cmd(8'h03, 24'h7E5A11, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cmd(8'h0B, 24'h800000, 1'b1, 300, 1'b0, 1'b0, 1'b0, 1'b0);
    stat_q = '{8'h00};
    run_cmd(8'h02, 24'hFFFF00, 1'b1, 511, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      a    = 24'($urandom);
      ha   = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      wren = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      len  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      stat_q.delete();
      for (int k = 0; k < 3; k++)
        stat_q.push_back({rnd8() & 8'hFE} | 8'(($urandom_range(0, 2) != 0) ? 1 : 0));
      run_cmd(rnd8(), a, ha, len, wr, wren, hold, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
